// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined subtractor: default geometry and the
// payload carried from stage 1 to stage 2.
package sub_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SPLIT = 32;
    localparam int DEF_HI    = DEF_WIDTH - DEF_SPLIT;

    // Everything stage 2 needs to finish the subtraction. The high operand
    // slices travel raw, and the low-slice carry links the two halves of the
    // carry chain. The sign bits are kept separately so the overflow
    // expression reads directly in terms of the operand signs.
    typedef struct packed {
        logic [DEF_SPLIT-1:0] lo_diff;
        logic                 lo_carry;
        logic [DEF_HI-1:0]    a_hi;
        logic [DEF_HI-1:0]    b_hi;
        logic                 a_sign;
        logic                 b_sign;
    } s1_payload_t;

endpackage

// File: rtl/sub_slice_str.sv
// Combinational N-bit subtract slice computed as a + ~b + cin.
// cout is the carry out of the slice. Its inverse is the borrow out.
module sub_slice_str #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] diff,
    output logic         cout
);

    // One extended-width add gives both the slice result and its carry out.
    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/pipelined_sub_str.sv
// Two-stage pipelined subtractor: diff = a - b - borrow_in.
// Stage 1 computes the low SPLIT bits and registers the carry between the two
// halves. Stage 2 finishes the high slice and drives the registered outputs.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds a, b and borrow_in stable while
// in_valid && !in_ready. The outputs hold stable while
// out_valid && !out_ready. in_ready depends only on internal state and
// out_ready. It has no combinational path from in_valid.
//
// The stage-1 payload uses the package type, so WIDTH and SPLIT must match
// DEF_WIDTH and DEF_SPLIT.
module pipelined_sub_str
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPLIT = DEF_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int HI = WIDTH - SPLIT;

    logic              s1_valid;
    s1_payload_t       s1_q;
    logic [SPLIT-1:0]  lo_diff;
    logic              lo_carry;
    logic [HI-1:0]     hi_diff;
    logic              hi_carry;
    logic              advance2;
    logic              accept;

    // Stage 2 takes the stage-1 contents whenever the output register is
    // free or is being emptied this cycle. Stage 1 can then refill in the
    // same cycle, so no bubbles are inserted.
    assign advance2 = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || advance2;
    assign accept   = in_valid && in_ready;

    // The carry into bit 0 is the inverted borrow in.
    sub_slice_str #(.N(SPLIT)) u_lo (
        .a    (a[SPLIT-1:0]),
        .b    (b[SPLIT-1:0]),
        .cin  (~borrow_in),
        .diff (lo_diff),
        .cout (lo_carry)
    );

    // The high slice continues the carry chain from the registered low carry.
    sub_slice_str #(.N(HI)) u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.b_hi),
        .cin  (s1_q.lo_carry),
        .diff (hi_diff),
        .cout (hi_carry)
    );

    // Stage 1 register: capture the low result and the high operands on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid      <= 1'b1;
            s1_q.lo_diff  <= lo_diff;
            s1_q.lo_carry <= lo_carry;
            s1_q.a_hi     <= a[WIDTH-1:SPLIT];
            s1_q.b_hi     <= b[WIDTH-1:SPLIT];
            s1_q.a_sign   <= a[WIDTH-1];
            s1_q.b_sign   <= b[WIDTH-1];
        end else if (advance2) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: load the full result when stage 1 advances, and drop
    // valid once the consumer has taken the result and nothing replaces it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (advance2) begin
            out_valid  <= 1'b1;
            diff       <= {hi_diff, s1_q.lo_diff};
            borrow_out <= ~hi_carry;
            overflow   <= (s1_q.a_sign != s1_q.b_sign) && (hi_diff[HI-1] != s1_q.a_sign);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_sub_str.sv
// Bench for pipelined_sub_str: directed scenario tasks plus a randomized
// stream scored against a behavioural reference.
module tb_pipelined_sub_str;

    localparam int W = 64;
    localparam int N_RAND = 10000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    pipelined_sub_str dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic last_in_acc = 1'b0;
    logic held_v = 1'b0;
    logic [W+1:0] held = '0;

    // Behavioural reference: {diff, borrow_out, overflow}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0]   t;
        logic [W-1:0] d;
        logic         ov;
        t  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        d  = t[W-1:0];
        ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
        return {d, t[W], ov};
    endfunction

    // One clock: sample both handshakes at the falling edge, then move to
    // just after the next rising edge where the drivers update inputs.
    task automatic step();
        logic [W+1:0] got;
        logic [W+1:0] e;
        @(negedge clk);
        got = {diff, borrow_out, overflow};
        last_in_acc = rst_n && in_valid && in_ready;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                total++;
                if (out_valid !== 1'b1 || got !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h required v=1 %h", out_valid, got, held);
                end
            end
            held_v = out_valid && !out_ready;
            held   = got;
            if (in_valid && in_ready) exp_q.push_back(model(a, b, borrow_in));
            if (out_valid && out_ready) begin
                total++;
                n_out++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %h with empty expected queue", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL scoreboard: got %h required %h", got, e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one operation and wait until it has been accepted.
    task automatic send_wait(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        n = 0;
        a = x; b = y; borrow_in = c; in_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_in_acc && n < 20);
        in_valid = 1'b0;
        if (!last_in_acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept in %0d cycles required accept", n);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 64'h1234; b = 64'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: got v=%b d=%h bo=%b ov=%b required all 0",
                         out_valid, diff, borrow_out, overflow);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_wait(64'h0000_0001_0000_0000, 64'd1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: got out_valid=%b required 0", out_valid);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || diff !== 64'h0000_0000_FFFF_FFFF || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_cross_slice: got v=%b d=%h bo=%b ov=%b required 1 00000000ffffffff 0 0",
                     out_valid, diff, borrow_out, overflow);
        end
        step();
    endtask

    task automatic test_underflow();
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        logic [W-1:0] td[2];
        logic         tbo[2];
        logic         tov[2];
        ta[0] = 64'd0;                  tb[0] = 64'd1; td[0] = {W{1'b1}};
        tbo[0] = 1'b1; tov[0] = 1'b0;
        ta[1] = 64'h8000_0000_0000_0000; tb[1] = 64'd1; td[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        tbo[1] = 1'b0; tov[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_wait(ta[i], tb[i], 1'b0);
            step();
            total++;
            if (out_valid !== 1'b1 || diff !== td[i] || borrow_out !== tbo[i] || overflow !== tov[i]) begin
                bad++;
                $display("FAIL underflow_%0d: got v=%b d=%h bo=%b ov=%b required 1 %h %b %b",
                         i, out_valid, diff, borrow_out, overflow, td[i], tbo[i], tov[i]);
            end
            step();
        end
    endtask

    task automatic test_borrow_in();
        logic [W-1:0] tb[2];
        logic [W-1:0] td[2];
        logic         tbo[2];
        tb[0] = 64'd5; td[0] = {W{1'b1}}; tbo[0] = 1'b1;
        tb[1] = 64'd3; td[1] = 64'd1;     tbo[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_wait(64'd5, tb[i], 1'b1);
            step();
            total++;
            if (out_valid !== 1'b1 || diff !== td[i] || borrow_out !== tbo[i] || overflow !== 1'b0) begin
                bad++;
                $display("FAIL borrow_in_%0d: got v=%b d=%h bo=%b ov=%b required 1 %h %b 0",
                         i, out_valid, diff, borrow_out, overflow, td[i], tbo[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int k_in;
        int k_out;
        int cyc;
        out_ready = 1'b0;
        k_in = 0;
        cyc = 0;
        a = 64'd17; b = 64'd7; borrow_in = 1'b0; in_valid = 1'b1;
        while (k_in < 2 && cyc < 10) begin
            step();
            cyc++;
            if (last_in_acc) begin
                k_in++;
                a = 64'(10 * (k_in + 1) + 7);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff !== 64'd10) begin
                bad++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%0d required 0 1 10",
                         i, in_ready, out_valid, diff);
            end
            step();
        end
        out_ready = 1'b1;
        k_out = 0;
        cyc = 0;
        while (k_out < 4 && cyc < 12) begin
            total++;
            if (out_valid !== 1'b1 || diff !== 64'(10 * (k_out + 1))) begin
                bad++;
                $display("FAIL bp_drain_%0d: got v=%b d=%0d required 1 %0d",
                         k_out, out_valid, diff, 10 * (k_out + 1));
            end
            k_out++;
            step();
            cyc++;
            if (last_in_acc) begin
                k_in++;
                if (k_in < 4) a = 64'(10 * (k_in + 1) + 7);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || k_in != 4) begin
            bad++;
            $display("FAIL bp_end: got v=%b accepted=%0d required v=0 accepted=4", out_valid, k_in);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        int cyc;
        out_ready = 1'b0;
        k = 0;
        cyc = 0;
        a = 64'd111; b = 64'd0; borrow_in = 1'b0; in_valid = 1'b1;
        while (k < 2 && cyc < 10) begin
            step();
            cyc++;
            if (last_in_acc) begin
                k++;
                a = 64'd222;
            end
        end
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_full: got rdy=%b v=%b required 0 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        exp_q.delete();
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale_%0d: got out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        logic pending;
        sent = 0;
        cyc = 0;
        pending = 1'b0;
        n_out = 0;
        while ((sent < N_RAND || exp_q.size() > 0) && cyc < 60000) begin
            if (!pending && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: begin a = {$urandom, $urandom}; b = a; end
                    1: begin a = {W{1'b1}}; b = {$urandom, $urandom}; end
                    2: begin a = {$urandom, $urandom}; b = {32'h0, $urandom}; end
                    default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
                endcase
                borrow_in = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                pending = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            if (last_in_acc) begin
                pending = 1'b0;
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (n_out != N_RAND || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_count: got %0d results (%0d left) in %0d cycles required %0d",
                     n_out, exp_q.size(), cyc, N_RAND);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_in();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
